// File: rtl/fp_issue_unit_if.sv
// Issue and writeback handshake bundle between the integer pipeline and the FP issue unit.
interface fp_issue_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_ADDR   = 4
);
    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic                  issue_op_i;
    logic [2:0]            issue_rnd_i;
    logic [DATA_WIDTH-1:0] issue_a_i;
    logic [DATA_WIDTH-1:0] issue_b_i;
    logic [REG_ADDR-1:0]   issue_rd_i;
    logic                  wb_valid_o;
    logic [REG_ADDR-1:0]   wb_rd_o;
    logic [DATA_WIDTH-1:0] wb_data_o;
    logic                  wb_ready_i;

    modport slave (
        input  issue_valid_i, issue_op_i, issue_rnd_i, issue_a_i, issue_b_i, issue_rd_i,
        input  wb_ready_i,
        output issue_ready_o, wb_valid_o, wb_rd_o, wb_data_o
    );

    modport master (
        output issue_valid_i, issue_op_i, issue_rnd_i, issue_a_i, issue_b_i, issue_rd_i,
        output wb_ready_i,
        input  issue_ready_o, wb_valid_o, wb_rd_o, wb_data_o
    );
endinterface

// File: rtl/fp_issue_unit.sv
// Single-outstanding FP issue unit: hands one operation to a fixed-latency coprocessor,
// waits out its pipeline, writes the result back and accumulates sticky status.
module fp_issue_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int STATUS_BIT = 8,
    parameter int LATENCY    = 1,
    parameter int REG_ADDR   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_issue_unit_if.slave        bus,
    output logic [DATA_WIDTH-1:0] cop_a_o,
    output logic [DATA_WIDTH-1:0] cop_b_o,
    output logic                  cop_op_o,
    output logic [2:0]            cop_rnd_o,
    input  logic [DATA_WIDTH-1:0] cop_data_i,
    input  logic [STATUS_BIT-1:0] cop_status_i,
    output logic [STATUS_BIT-1:0] fsr_o,
    input  logic                  fsr_clr_i,
    input  logic [STATUS_BIT-1:0] exc_mask_i,
    output logic                  exc_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, WAIT, WB} state_t;

    localparam logic [2:0] LAT = 3'(LATENCY);

    state_t                state_q, state_d;
    logic [2:0]            waitCnt_q, waitCnt_d;
    logic [DATA_WIDTH-1:0] copA_q, copA_d;
    logic [DATA_WIDTH-1:0] copB_q, copB_d;
    logic                  copOp_q, copOp_d;
    logic [2:0]            copRnd_q, copRnd_d;
    logic [REG_ADDR-1:0]   rd_q, rd_d;
    logic [DATA_WIDTH-1:0] wbData_q, wbData_d;
    logic                  wbValid_q, wbValid_d;
    logic [STATUS_BIT-1:0] fsr_q, fsr_d;
    logic                  exc_q, exc_d;
    logic                  issueReady;
    logic                  capture;
    logic [STATUS_BIT-1:0] fsrBase;

    // Readiness is held off while reset is asserted so nothing is offered mid-reset.
    assign issueReady = rst && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        copA_d    = copA_q;
        copB_d    = copB_q;
        copOp_d   = copOp_q;
        copRnd_d  = copRnd_q;
        rd_d      = rd_q;
        wbData_d  = wbData_q;
        wbValid_d = wbValid_q;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.issue_valid_i && issueReady) begin
                    copA_d    = bus.issue_a_i;
                    copB_d    = bus.issue_b_i;
                    copOp_d   = bus.issue_op_i;
                    copRnd_d  = bus.issue_rnd_i;
                    rd_d      = bus.issue_rd_i;
                    waitCnt_d = LAT;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (waitCnt_q == 3'd0) begin
                    capture   = 1'b1;
                    wbData_d  = cop_data_i;
                    wbValid_d = 1'b1;
                    state_d   = WB;
                end else begin
                    waitCnt_d = waitCnt_q - 3'd1;
                end
            end
            WB: begin
                if (bus.wb_ready_i) begin
                    wbValid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear takes effect before the capture OR so a coincident clear keeps only new flags.
        fsrBase = fsr_clr_i ? '0 : fsr_q;
        fsr_d   = capture ? (fsrBase | cop_status_i) : fsrBase;
        exc_d   = capture && ((cop_status_i & exc_mask_i) != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            waitCnt_q <= 3'd0;
            copA_q    <= '0;
            copB_q    <= '0;
            copOp_q   <= 1'b0;
            copRnd_q  <= 3'd0;
            rd_q      <= '0;
            wbData_q  <= '0;
            wbValid_q <= 1'b0;
            fsr_q     <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            copA_q    <= copA_d;
            copB_q    <= copB_d;
            copOp_q   <= copOp_d;
            copRnd_q  <= copRnd_d;
            rd_q      <= rd_d;
            wbData_q  <= wbData_d;
            wbValid_q <= wbValid_d;
            fsr_q     <= fsr_d;
            exc_q     <= exc_d;
        end
    end

    assign bus.issue_ready_o = issueReady;
    assign bus.wb_valid_o    = wbValid_q;
    assign bus.wb_rd_o       = rd_q;
    assign bus.wb_data_o     = wbData_q;
    assign cop_a_o           = copA_q;
    assign cop_b_o           = copB_q;
    assign cop_op_o          = copOp_q;
    assign cop_rnd_o         = copRnd_q;
    assign fsr_o             = fsr_q;
    assign exc_o             = exc_q;
    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_fp_issue_unit.sv
// Directed bench for fp_issue_unit: one LATENCY=1 instance and one LATENCY=3 instance
// fed by hand-written vectors with a stub coprocessor driven from the bench.
module tb_fp_issue_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    fp_issue_unit_if #(.DATA_WIDTH(16), .REG_ADDR(4)) bus1 ();
    fp_issue_unit_if #(.DATA_WIDTH(16), .REG_ADDR(4)) bus3 ();

    logic [15:0] copA1, copB1, copData1, copA3, copB3, copData3;
    logic        copOp1, copOp3, fsrClr1, fsrClr3, exc1, exc3, busy1, busy3;
    logic [2:0]  copRnd1, copRnd3;
    logic [7:0]  copStatus1, copStatus3, fsr1, fsr3, excMask1, excMask3;

    fp_issue_unit #(.DATA_WIDTH(16), .STATUS_BIT(8), .LATENCY(1), .REG_ADDR(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .cop_a_o(copA1), .cop_b_o(copB1), .cop_op_o(copOp1), .cop_rnd_o(copRnd1),
        .cop_data_i(copData1), .cop_status_i(copStatus1),
        .fsr_o(fsr1), .fsr_clr_i(fsrClr1), .exc_mask_i(excMask1), .exc_o(exc1), .busy_o(busy1)
    );

    fp_issue_unit #(.DATA_WIDTH(16), .STATUS_BIT(8), .LATENCY(3), .REG_ADDR(4)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave),
        .cop_a_o(copA3), .cop_b_o(copB3), .cop_op_o(copOp3), .cop_rnd_o(copRnd3),
        .cop_data_i(copData3), .cop_status_i(copStatus3),
        .fsr_o(fsr3), .fsr_clr_i(fsrClr3), .exc_mask_i(excMask3), .exc_o(exc3), .busy_o(busy3)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on dut1, feed junk while waiting, present the real result only for the capture edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic op,
                                 input logic [2:0] rnd, input logic [3:0] rd,
                                 input logic [15:0] data, input logic [7:0] status, input logic clr);
        bus1.issue_valid_i = 1'b1;
        bus1.issue_a_i     = a;
        bus1.issue_b_i     = b;
        bus1.issue_op_i    = op;
        bus1.issue_rnd_i   = rnd;
        bus1.issue_rd_i    = rd;
        tick();
        bus1.issue_valid_i = 1'b0;
        copData1   = 16'hDEAD;
        copStatus1 = 8'hFF;
        tick();
        checkOutput("wait_no_wb", 32'(bus1.wb_valid_o), 32'd0);
        copData1   = data;
        copStatus1 = status;
        fsrClr1    = clr;
        tick();
        fsrClr1    = 1'b0;
        copData1   = 16'hDEAD;
        copStatus1 = 8'hFF;
    endtask

    task automatic finishWb();
        bus1.wb_ready_i = 1'b1;
        tick();
        bus1.wb_ready_i = 1'b0;
        checkOutput("wb_done_valid", 32'(bus1.wb_valid_o), 32'd0);
        checkOutput("wb_done_busy", 32'(busy1), 32'd0);
    endtask

    initial begin
        bus1.issue_valid_i = 0; bus1.issue_op_i = 0; bus1.issue_rnd_i = 0;
        bus1.issue_a_i = 0; bus1.issue_b_i = 0; bus1.issue_rd_i = 0; bus1.wb_ready_i = 0;
        bus3.issue_valid_i = 0; bus3.issue_op_i = 0; bus3.issue_rnd_i = 0;
        bus3.issue_a_i = 0; bus3.issue_b_i = 0; bus3.issue_rd_i = 0; bus3.wb_ready_i = 0;
        copData1 = 0; copStatus1 = 0; fsrClr1 = 0; excMask1 = 0;
        copData3 = 0; copStatus3 = 0; fsrClr3 = 0; excMask3 = 0;

        #2;
        checkOutput("rst_wb_valid", 32'(bus1.wb_valid_o), 32'd0);
        checkOutput("rst_fsr", 32'(fsr1), 32'd0);
        checkOutput("rst_cop_a", 32'(copA1), 32'd0);
        checkOutput("rst_busy", 32'(busy1), 32'd0);
        checkOutput("rst_exc", 32'(exc1), 32'd0);
        checkOutput("rst_ready", 32'(bus1.issue_ready_o), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("post_rst_ready", 32'(bus1.issue_ready_o), 32'd1);

        // Add 1.0 + 2.0 = 3.0, then back-pressure the writeback.
        applyStimulus(16'h3C00, 16'h4000, 1'b0, 3'd0, 4'd3, 16'h4200, 8'h00, 1'b0);
        checkOutput("add_cop_a", 32'(copA1), 32'h3C00);
        checkOutput("add_cop_b", 32'(copB1), 32'h4000);
        checkOutput("add_wb_valid", 32'(bus1.wb_valid_o), 32'd1);
        checkOutput("add_wb_rd", 32'(bus1.wb_rd_o), 32'd3);
        checkOutput("add_wb_data", 32'(bus1.wb_data_o), 32'h4200);
        checkOutput("add_fsr", 32'(fsr1), 32'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_valid", 32'(bus1.wb_valid_o), 32'd1);
            checkOutput("bp_data", 32'(bus1.wb_data_o), 32'h4200);
            checkOutput("bp_rd", 32'(bus1.wb_rd_o), 32'd3);
            checkOutput("bp_ready", 32'(bus1.issue_ready_o), 32'd0);
            checkOutput("bp_busy", 32'(busy1), 32'd1);
            checkOutput("bp_fsr", 32'(fsr1), 32'h00);
        end
        // A valid issue at the writeback-completion edge must not be taken.
        bus1.issue_valid_i = 1'b1;
        bus1.issue_a_i = 16'h1234;
        finishWb();
        checkOutput("idle_ready", 32'(bus1.issue_ready_o), 32'd1);
        checkOutput("no_accept_cop_a", 32'(copA1), 32'h3C00);

        // Overflow multiply with overflow exceptions enabled.
        excMask1 = 8'h10;
        applyStimulus(16'h7BFF, 16'h7BFF, 1'b1, 3'd0, 4'd5, 16'h7C00, 8'h30, 1'b0);
        checkOutput("ovf_cop_op", 32'(copOp1), 32'd1);
        checkOutput("ovf_cop_rnd", 32'(copRnd1), 32'd0);
        checkOutput("ovf_wb_data", 32'(bus1.wb_data_o), 32'h7C00);
        checkOutput("ovf_wb_rd", 32'(bus1.wb_rd_o), 32'd5);
        checkOutput("ovf_fsr", 32'(fsr1), 32'h30);
        checkOutput("ovf_exc_hi", 32'(exc1), 32'd1);
        bus1.wb_ready_i = 1'b1;
        tick();
        bus1.wb_ready_i = 1'b0;
        checkOutput("ovf_exc_lo", 32'(exc1), 32'd0);
        checkOutput("ovf_wb_gone", 32'(bus1.wb_valid_o), 32'd0);
        checkOutput("ovf_fsr_hold", 32'(fsr1), 32'h30);
        tick();

        fsrClr1 = 1'b1;
        tick();
        fsrClr1 = 1'b0;
        checkOutput("clr_fsr", 32'(fsr1), 32'h00);

        applyStimulus(16'h4000, 16'h4000, 1'b1, 3'd1, 4'd2, 16'h4400, 8'h20, 1'b0);
        checkOutput("inexact_fsr", 32'(fsr1), 32'h20);
        checkOutput("masked_exc", 32'(exc1), 32'd0);
        finishWb();
        tick();

        applyStimulus(16'h3C00, 16'h3C00, 1'b0, 3'd2, 4'd9, 16'h4000, 8'h01, 1'b1);
        checkOutput("clr_cap_fsr", 32'(fsr1), 32'h01);
        checkOutput("clr_cap_rnd", 32'(copRnd1), 32'd2);
        finishWb();
        tick();

        // Reset one cycle after accept aborts the operation.
        bus1.issue_valid_i = 1'b1;
        bus1.issue_a_i = 16'h5555; bus1.issue_b_i = 16'h6666; bus1.issue_rd_i = 4'd7;
        tick();
        bus1.issue_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("abort_cop_a", 32'(copA1), 32'd0);
        checkOutput("abort_cop_b", 32'(copB1), 32'd0);
        checkOutput("abort_busy", 32'(busy1), 32'd0);
        checkOutput("abort_fsr", 32'(fsr1), 32'd0);
        checkOutput("abort_wb_rd", 32'(bus1.wb_rd_o), 32'd0);
        copData1 = 16'hABCD; copStatus1 = 8'h08;
        tick();
        checkOutput("abort_no_wb", 32'(bus1.wb_valid_o), 32'd0);
        checkOutput("abort_no_fsr", 32'(fsr1), 32'd0);
        rst = 1'b1;
        tick();
        applyStimulus(16'h4400, 16'h3C00, 1'b0, 3'd0, 4'd1, 16'h4500, 8'h04, 1'b0);
        checkOutput("after_rst_data", 32'(bus1.wb_data_o), 32'h4500);
        checkOutput("after_rst_rd", 32'(bus1.wb_rd_o), 32'd1);
        checkOutput("after_rst_fsr", 32'(fsr1), 32'h04);
        finishWb();

        // LATENCY=3: 2.0 * 3.0 = 6.0, with noisy issue traffic during WAIT.
        bus3.issue_valid_i = 1'b1;
        bus3.issue_a_i = 16'h4000; bus3.issue_b_i = 16'h4200;
        bus3.issue_op_i = 1'b1; bus3.issue_rnd_i = 3'd3; bus3.issue_rd_i = 4'd7;
        tick();
        copData3 = 16'hBEEF; copStatus3 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            bus3.issue_valid_i = (i != 1);
            bus3.issue_a_i = 16'h1111 + 16'(i); bus3.issue_b_i = 16'h2222;
            bus3.issue_op_i = 1'b0; bus3.issue_rnd_i = 3'd5; bus3.issue_rd_i = 4'd1;
            if (i == 2) begin
                bus3.issue_valid_i = 1'b0;
                copData3 = 16'h4600; copStatus3 = 8'h00;
            end
            tick();
            checkOutput("l3_cop_a", 32'(copA3), 32'h4000);
            checkOutput("l3_cop_b", 32'(copB3), 32'h4200);
            checkOutput("l3_cop_op", 32'(copOp3), 32'd1);
            checkOutput("l3_cop_rnd", 32'(copRnd3), 32'd3);
            checkOutput("l3_wb_valid", 32'(bus3.wb_valid_o), (i == 2) ? 32'd0 : 32'd0);
        end
        tick();
        checkOutput("l3_cap_valid", 32'(bus3.wb_valid_o), 32'd1);
        checkOutput("l3_cap_data", 32'(bus3.wb_data_o), 32'h4600);
        checkOutput("l3_cap_rd", 32'(bus3.wb_rd_o), 32'd7);
        checkOutput("l3_cap_fsr", 32'(fsr3), 32'h00);
        bus3.wb_ready_i = 1'b1;
        tick();
        bus3.wb_ready_i = 1'b0;
        checkOutput("l3_done_valid", 32'(bus3.wb_valid_o), 32'd0);
        checkOutput("l3_done_busy", 32'(busy3), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_issue_unit.md
FP_ISSUE_UNIT -- requirements
Module: fp_issue_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning operand and result width.
REQ-002 SHALL have parameter STATUS_BIT, default 8, meaning coprocessor status width.
REQ-003 SHALL have parameter LATENCY, default 1, meaning the number of coprocessor register stages (range 1-7).
REQ-004 SHALL have parameter REG_ADDR, default 4, meaning destination register index width.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all flops are rising-edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port issue_valid_i, input, 1 bit: pipeline presents an FP operation.
REQ-008 SHALL have port issue_ready_o, output, 1 bit: unit accepts the operation this cycle.
REQ-009 SHALL have port issue_op_i, input, 1 bit: 0 = add, 1 = multiply.
REQ-010 SHALL have port issue_rnd_i, input, 3 bits: rounding mode.
REQ-011 SHALL have ports issue_a_i and issue_b_i, inputs, DATA_WIDTH each: operands.
REQ-012 SHALL have port issue_rd_i, input, REG_ADDR bits: destination register.
REQ-013 SHALL have ports cop_a_o, cop_b_o (DATA_WIDTH), cop_op_o (1), cop_rnd_o (3), all outputs, all registered: drive coprocessor.
REQ-014 SHALL have ports cop_data_i (DATA_WIDTH) and cop_status_i (STATUS_BIT), both inputs: registered coprocessor result.
REQ-015 SHALL have ports wb_valid_o (1), wb_rd_o (REG_ADDR), wb_data_o (DATA_WIDTH), all outputs, and wb_ready_i, input (1): writeback handshake.
REQ-016 SHALL have port fsr_o, output, STATUS_BIT: sticky status; fsr_clr_i, input (1): clear sticky status.
REQ-017 SHALL have port exc_mask_i, input, STATUS_BIT: exception enables; exc_o, output (1): exception pulse.
REQ-018 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, WAIT and WB.
REQ-020 SHALL drive issue_ready_o = 1 only in IDLE; accept happens when issue_valid_i & issue_ready_o are high at a rising edge.
REQ-021 On accept, SHALL load cop_a_o/cop_b_o/cop_op_o/cop_rnd_o and latch issue_rd_i, load the wait counter with LATENCY, and go to WAIT.
REQ-022 SHALL hold the cop_* outputs stable from accept until the next accept.
REQ-023 In WAIT, SHALL decrement the counter each edge; at the edge where the counter equals 0 it SHALL capture cop_data_i into wb_data_o, assert wb_valid_o and go to WB. An accept at edge E0 therefore gives capture at E0+LATENCY+1.
REQ-024 In WB, SHALL hold wb_valid_o, wb_rd_o and wb_data_o stable until wb_ready_i is high at an edge, then deassert wb_valid_o and return to IDLE.
REQ-025 SHALL NOT accept a new issue in the same cycle a writeback completes; the earliest next accept is one cycle after return to IDLE.
REQ-026 At the capture edge, SHALL compute fsr_o <= fsr_o | cop_status_i.
REQ-027 SHALL clear fsr_o to 0 on fsr_clr_i.
REQ-028 When fsr_clr_i coincides with a capture edge, fsr_o SHALL become cop_status_i: the clear applies first, then the OR.
REQ-029 SHALL pulse exc_o high for exactly one cycle after a capture edge where (cop_status_i & exc_mask_i) != 0; the writeback still proceeds.
REQ-030 SHALL ignore issue_valid_i and issue_* inputs outside IDLE.
REQ-031 SHALL ignore cop_data_i and cop_status_i except at the capture edge.

Reset
REQ-032 While rst is low, asynchronously: state = IDLE, counter = 0, and cop_a_o, cop_b_o, cop_op_o, cop_rnd_o, wb_valid_o, wb_rd_o, wb_data_o, fsr_o, exc_o, busy_o = 0. issue_ready_o goes high after reset is released.
REQ-033 Reset asserted during WAIT or WB SHALL abort the operation: no writeback and no fsr_o update occur.

Verification
REQ-034 Add, LATENCY=1: issue a=0x3C00, b=0x4000, op=0, rd=3 -> at E0+2 wb_valid_o=1, wb_rd_o=3, wb_data_o=0x4200, fsr_o unchanged (0).
REQ-035 Back-pressure: hold wb_ready_i=0 for 5 cycles -> wb_* stable, issue_ready_o=0, busy_o=1; release -> one writeback, IDLE next cycle.
REQ-036 Overflow: mult 0x7BFF*0x7BFF, rnd=0, exc_mask_i=0x10 -> fsr_o has bits 4 and 5 set, exc_o high for exactly one cycle, wb_data_o=0x7C00.
REQ-037 Simultaneous clear: fsr_o=0x20 and fsr_clr_i=1 at a capture edge with cop_status_i=0x01 -> fsr_o=0x01.
REQ-038 Reset mid-WAIT: drop rst one cycle after accept -> all outputs 0 immediately, no wb_valid_o; after release, a new issue completes normally.
REQ-039 LATENCY=3: capture at E0+4; issue_valid_i toggled during WAIT with differing operands -> no effect on cop_* or the result.
